adc_scan_sequencer: RTL and testbench

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

---
 rtl/adc_scan_pkg.sv | 19 +
 rtl/adc_scan_timer.sv | 51 +++++
 rtl/adc_scan_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_scan_pkg.sv
// Shared types and defaults for the ADC scan sequencer.
package adc_scan_pkg;

  localparam int NUM_CH_DEF = 8;
  localparam int DATA_W_DEF = 12;
  localparam int CH_IDX_W   = 3;

  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_CLR,
    WAIT_DONE,
    STORE,
    PERIOD_WAIT
  } scan_state_t;

endpackage

// File: rtl/adc_scan_timer.sv
// Scan period counter: restarts on every scan start, saturates at the period,
// flags when the next scan is due and latches overrun when a scan ends late.
module adc_scan_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_restart,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_scan_end,
  input  logic                i_clear,
  output logic                o_hit,
  output logic                o_overrun
);

  logic [PERIOD_W-1:0] r_cnt;
  logic                r_overrun;
  logic [PERIOD_W:0]   w_cnt_inc;
  logic                w_late;

  // Periods of 0 or 1 always count as due, giving back-to-back scans.
  assign w_cnt_inc = {1'b0, r_cnt} + (PERIOD_W + 1)'(1);
  assign o_hit     = (w_cnt_inc >= {1'b0, i_period});
  // Late only when the count already reached the period; tiny periods are
  // an explicit back-to-back request, not an overrun.
  assign w_late    = (i_period > PERIOD_W'(1)) && (r_cnt >= i_period);
  assign o_overrun = r_overrun;

  // Period counter, zeroed at each scan start and held at the period value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (r_cnt < i_period) begin
      r_cnt <= r_cnt + PERIOD_W'(1);
    end
  end

  // Sticky overrun; a new overrun in the same cycle beats the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (i_scan_end && w_late) begin
      r_overrun <= 1'b1;
    end else if (i_clear) begin
      r_overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Walks the enabled ADC channels lowest-first, handshaking with the external
// driver for each conversion and storing results in a per-channel bank.
module adc_scan_sequencer
  import adc_scan_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 1023,
  parameter int PERIOD_W    = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_CH-1:0]   i_ch_enable,
  input  logic                i_scan_start,
  input  logic                i_continuous,
  input  logic [PERIOD_W-1:0] i_scan_period,
  input  logic                i_clear_status,
  input  logic [CH_IDX_W-1:0] i_rd_ch,
  output logic [DATA_W-1:0]   o_rd_data,
  output logic [NUM_CH-1:0]   o_result_valid,
  output logic                o_busy,
  output logic                o_scan_done,
  output logic                o_timeout_err,
  output logic                o_overrun,
  output logic                o_measure_start,
  output logic [CH_IDX_W-1:0] o_measure_ch,
  input  logic                i_measure_done,
  input  logic [DATA_W-1:0]   i_measure_dataread
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  scan_state_t       r_state, w_state_next;
  logic [NUM_CH-1:0] r_scan_mask;
  ch_idx_t           r_measure_ch;
  logic              r_measure_start, r_scan_done, r_timeout_err, r_skip;
  logic [TO_W-1:0]   r_to_cnt;
  logic [DATA_W-1:0] r_result [NUM_CH];
  logic [NUM_CH-1:0] r_result_valid;

  logic [NUM_CH-1:0] w_ch_onehot, w_mask_rem, w_valid_next;
  logic [DATA_W-1:0] w_rd_bank [8];
  logic w_en_any, w_rem_any, w_to_expired, w_period_hit, w_overrun;
  logic w_timeout, w_store_ok, w_scan_end, w_launch, w_empty_scan, w_busy;

  // Lowest set bit of a channel mask.
  function automatic ch_idx_t lowest_ch(input logic [NUM_CH-1:0] m);
    ch_idx_t idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = ch_idx_t'(i);
    end
    return idx;
  endfunction

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_onehot
    assign w_ch_onehot[gi] = (r_measure_ch == ch_idx_t'(gi));
  end

  // Read mux padded to the full 3-bit select range; unused slots read zero.
  for (genvar gi = 0; gi < 8; gi++) begin : g_rd
    if (gi < NUM_CH) begin : g_real
      assign w_rd_bank[gi] = r_result[gi];
    end else begin : g_pad
      assign w_rd_bank[gi] = '0;
    end
  end

  assign w_mask_rem   = r_scan_mask & ~w_ch_onehot;
  assign w_en_any     = |i_ch_enable;
  assign w_rem_any    = |w_mask_rem;
  assign w_to_expired = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:        if (i_scan_start && w_en_any) w_state_next = START;
      START:       w_state_next = WAIT_CLR;
      WAIT_CLR:    if (!i_measure_done) w_state_next = WAIT_DONE;
                   else if (w_to_expired) w_state_next = STORE;
      WAIT_DONE:   if (i_measure_done || w_to_expired) w_state_next = STORE;
      STORE: begin
        if (w_rem_any)          w_state_next = START;
        else if (!i_continuous) w_state_next = IDLE;
        else if (w_period_hit)  w_state_next = w_en_any ? START : PERIOD_WAIT;
        else                    w_state_next = PERIOD_WAIT;
      end
      PERIOD_WAIT: begin
        if (!i_continuous)     w_state_next = IDLE;
        else if (w_period_hit) w_state_next = w_en_any ? START : PERIOD_WAIT;
      end
      default:     w_state_next = IDLE;
    endcase
  end

  // Decoded per-state actions.
  always_comb begin
    w_busy       = (r_state != IDLE) && (r_state != PERIOD_WAIT);
    w_timeout    = w_to_expired &&
                   (((r_state == WAIT_CLR) && i_measure_done) ||
                    ((r_state == WAIT_DONE) && !i_measure_done));
    w_store_ok   = (r_state == STORE) && !r_skip;
    w_scan_end   = (r_state == STORE) && !w_rem_any;
    w_launch     = ((r_state == IDLE) && i_scan_start) ||
                   (w_scan_end && i_continuous && w_period_hit) ||
                   ((r_state == PERIOD_WAIT) && i_continuous && w_period_hit);
    w_empty_scan = w_launch && !w_en_any;
  end

  // Handshake, channel walk and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_measure_start <= 1'b0;
      r_measure_ch    <= '0;
      r_scan_mask     <= '0;
      r_scan_done     <= 1'b0;
      r_timeout_err   <= 1'b0;
      r_skip          <= 1'b0;
      r_to_cnt        <= '0;
    end else begin
      // Dropping in STORE guarantees a low cycle before every new rise.
      r_measure_start <= (w_state_next == START) || (w_state_next == WAIT_CLR) ||
                         (w_state_next == WAIT_DONE);
      r_scan_done     <= w_scan_end || w_empty_scan;
      r_skip          <= w_timeout;
      r_to_cnt        <= (w_state_next != r_state) ? '0 : r_to_cnt + TO_W'(1);
      if (w_timeout)           r_timeout_err <= 1'b1;
      else if (i_clear_status) r_timeout_err <= 1'b0;
      if (w_launch) begin
        r_scan_mask  <= i_ch_enable;
        r_measure_ch <= lowest_ch(i_ch_enable);
      end else if (r_state == STORE) begin
        r_scan_mask <= w_mask_rem;
        if (w_rem_any) r_measure_ch <= lowest_ch(w_mask_rem);
      end
    end
  end

  // A store in the same cycle as clear_status keeps its own valid bit.
  assign w_valid_next = (i_clear_status ? '0 : r_result_valid) |
                        (w_store_ok ? w_ch_onehot : '0);

  // Result bank and valid flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) r_result[i] <= '0;
      r_result_valid <= '0;
    end else begin
      if (w_store_ok) r_result[r_measure_ch] <= i_measure_dataread;
      r_result_valid <= w_valid_next;
    end
  end

  adc_scan_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_restart  (w_launch),
    .i_period   (i_scan_period),
    .i_scan_end (w_scan_end && i_continuous),
    .i_clear    (i_clear_status),
    .o_hit      (w_period_hit),
    .o_overrun  (w_overrun)
  );

  assign o_rd_data       = w_rd_bank[i_rd_ch];
  assign o_result_valid  = r_result_valid;
  assign o_busy          = w_busy;
  assign o_scan_done     = r_scan_done;
  assign o_timeout_err   = r_timeout_err;
  assign o_overrun       = w_overrun;
  assign o_measure_start = r_measure_start;
  assign o_measure_ch    = r_measure_ch;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: behavioural ADC driver, channel-order
// scoreboard, a table of single scans and hand-written corner sequences.
module tb_adc_scan_sequencer;

  localparam int CONV = 396;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  i_ch_enable;
  logic        i_scan_start, i_continuous, i_clear_status;
  logic [23:0] i_scan_period;
  logic [2:0]  i_rd_ch;
  logic [11:0] o_rd_data;
  logic [7:0]  o_result_valid;
  logic        o_busy, o_scan_done, o_timeout_err, o_overrun, o_measure_start;
  logic [2:0]  o_measure_ch;
  logic        i_measure_done;
  logic [11:0] i_measure_dataread;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int idle_cnt = 0;
  int ch2_rise_cyc = 0;
  int to_rise_cyc = 0;
  int ch0_rises[$];
  int exp_ch_q[$];
  bit sb_en = 1'b1;
  int drv_mute_ch = 99;
  int drv_stale_hold = 0;

  typedef struct {
    logic [7:0] en;
    logic [7:0] exp_valid;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  adc_scan_sequencer dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .i_ch_enable        (i_ch_enable),
    .i_scan_start       (i_scan_start),
    .i_continuous       (i_continuous),
    .i_scan_period      (i_scan_period),
    .i_clear_status     (i_clear_status),
    .i_rd_ch            (i_rd_ch),
    .o_rd_data          (o_rd_data),
    .o_result_valid     (o_result_valid),
    .o_busy             (o_busy),
    .o_scan_done        (o_scan_done),
    .o_timeout_err      (o_timeout_err),
    .o_overrun          (o_overrun),
    .o_measure_start    (o_measure_start),
    .o_measure_ch       (o_measure_ch),
    .i_measure_done     (i_measure_done),
    .i_measure_dataread (i_measure_dataread)
  );

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    i_scan_start = 1'b1;
    tick(1);
    i_scan_start = 1'b0;
  endtask

  task automatic pulse_clear();
    i_clear_status = 1'b1;
    tick(1);
    i_clear_status = 1'b0;
  endtask

  task automatic push_mask(input logic [7:0] en);
    for (int i = 0; i < 8; i++) if (en[i]) exp_ch_q.push_back(i);
  endtask

  task automatic wait_done(input int base, input int limit, input string name);
    int n;
    n = 0;
    while (done_cnt <= base && n < limit) begin
      tick(1);
      n++;
    end
    check(name, longint'(done_cnt > base), 1);
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n;
    n = 0;
    while (o_busy && n < limit) begin
      tick(1);
      n++;
    end
    check(name, o_busy, 0);
  endtask

  // ADC driver model: done rises CONV cycles after each start edge with data
  // 0x100+ch; optional muted channel and stale-done hold.
  initial begin
    int cnt, stale, ch;
    bit prev, pending;
    cnt = 0; stale = 0; ch = 0; prev = 1'b0; pending = 1'b0;
    i_measure_done = 1'b0;
    i_measure_dataread = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        prev = 1'b0;
        pending = 1'b0;
        stale = 0;
      end else begin
        if (o_measure_start && !prev) begin
          ch = int'(o_measure_ch);
          cnt = 0;
          stale = drv_stale_hold;
          pending = (ch != drv_mute_ch);
          if (stale > 0) begin
            i_measure_done = 1'b1;
            i_measure_dataread = 12'hBAD;
          end else begin
            i_measure_done = 1'b0;
          end
        end else if (stale > 0) begin
          stale--;
          if (stale == 0) i_measure_done = 1'b0;
        end else if (pending) begin
          cnt++;
          if (cnt == CONV) begin
            i_measure_done = 1'b1;
            i_measure_dataread = 12'(32'h100 + ch);
            pending = 1'b0;
          end
        end
        prev = o_measure_start;
      end
    end
  end

  // Monitor: counts events and pops the expected channel on each start edge.
  initial begin
    bit prev_ms, prev_to;
    int e;
    prev_ms = 1'b0; prev_to = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (o_scan_done) done_cnt++;
      if (!o_busy) idle_cnt++;
      if (o_timeout_err && !prev_to) to_rise_cyc = cyc;
      if (o_measure_start && !prev_ms) begin
        if (o_measure_ch == 3'd0) ch0_rises.push_back(cyc);
        if (o_measure_ch == 3'd2) ch2_rise_cyc = cyc;
        if (sb_en) begin
          if (exp_ch_q.size() == 0) begin
            check("sb_unexpected_start", exp_ch_q.size(), 1);
          end else begin
            e = exp_ch_q.pop_front();
            check("sb_channel", o_measure_ch, e);
          end
        end
      end
      prev_ms = o_measure_start;
      prev_to = o_timeout_err;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base, d, n, ia, ib;
    vecs[0] = '{8'h81, 8'h81};
    vecs[1] = '{8'h01, 8'h01};
    vecs[2] = '{8'h80, 8'h80};
    vecs[3] = '{8'h55, 8'h55};
    vecs[4] = '{8'h00, 8'h00};
    i_ch_enable = '0; i_scan_start = 1'b0; i_continuous = 1'b0;
    i_scan_period = '0; i_clear_status = 1'b0; i_rd_ch = '0;
    #1 reset_n = 1'b0;
    tick(3);
    check("rst_busy", o_busy, 0);
    check("rst_measure_start", o_measure_start, 0);
    check("rst_measure_ch", o_measure_ch, 0);
    check("rst_valid", o_result_valid, 0);
    check("rst_scan_done", o_scan_done, 0);
    check("rst_timeout", o_timeout_err, 0);
    check("rst_overrun", o_overrun, 0);
    check("rst_rd_data", o_rd_data, 0);
    reset_n = 1'b1;
    tick(2);

    // Single scans from the table.
    for (int v = 0; v < 5; v++) begin
      pulse_clear();
      i_ch_enable = vecs[v].en;
      push_mask(vecs[v].en);
      base = done_cnt;
      pulse_start();
      wait_done(base, 4000, "scan_done_seen");
      tick(4);
      check("scan_done_count", done_cnt - base, 1);
      check("scan_valid", o_result_valid, vecs[v].exp_valid);
      check("sb_drained", exp_ch_q.size(), 0);
      check("idle_after_scan", o_busy, 0);
      for (int i = 0; i < 8; i++) begin
        if (vecs[v].exp_valid[i]) begin
          i_rd_ch = 3'(i);
          #1;
          check("rd_data", o_rd_data, 32'h100 + i);
        end
      end
    end

    // Channel 2 never answers: timeout, skip, scan still completes.
    pulse_clear();
    drv_mute_ch = 2;
    i_ch_enable = 8'h07;
    push_mask(8'h07);
    base = done_cnt;
    pulse_start();
    tick(500);
    check("timeout_early", o_timeout_err, 0);
    wait_done(base, 4000, "timeout_scan_done");
    tick(2);
    check("timeout_err", o_timeout_err, 1);
    check("timeout_valid", o_result_valid, 8'h03);
    d = to_rise_cyc - ch2_rise_cyc;
    check("timeout_latency_window", longint'(d >= 1023 && d <= 1027), 1);
    check("timeout_sb_drained", exp_ch_q.size(), 0);
    drv_mute_ch = 99;

    // Reset while waiting for the driver, with flags already set.
    i_ch_enable = 8'h80;
    push_mask(8'h80);
    pulse_start();
    tick(200);
    check("pre_reset_busy", o_busy, 1);
    reset_n = 1'b0;
    #1;
    check("arst_measure_start", o_measure_start, 0);
    check("arst_busy", o_busy, 0);
    check("arst_valid", o_result_valid, 0);
    check("arst_timeout", o_timeout_err, 0);
    check("arst_measure_ch", o_measure_ch, 0);
    check("arst_scan_done", o_scan_done, 0);
    i_rd_ch = 3'd0;
    #1;
    check("arst_result", o_rd_data, 0);
    exp_ch_q.delete();
    tick(3);
    reset_n = 1'b1;
    tick(3);
    check("post_reset_idle", o_busy, 0);

    // Stale done held high across the start edge.
    pulse_clear();
    drv_stale_hold = 60;
    i_ch_enable = 8'h08;
    push_mask(8'h08);
    base = done_cnt;
    pulse_start();
    tick(300);
    check("stale_ignored", o_result_valid, 0);
    wait_done(base, 4000, "stale_scan_done");
    tick(2);
    check("stale_valid", o_result_valid, 8'h08);
    i_rd_ch = 3'd3;
    #1;
    check("stale_rd_data", o_rd_data, 12'h103);
    check("stale_no_timeout", o_timeout_err, 0);
    drv_stale_hold = 0;

    // Ignored restart mid-scan, then clear_status coincident with STORE.
    i_ch_enable = 8'h01;
    push_mask(8'h01);
    base = done_cnt;
    pulse_start();
    tick(100);
    i_ch_enable = 8'h40;
    pulse_start();
    n = 0;
    while (o_measure_start && n < 1000) begin
      tick(1);
      n++;
    end
    check("store_reached", o_measure_start, 0);
    i_clear_status = 1'b1;
    tick(1);
    i_clear_status = 1'b0;
    wait_done(base, 100, "clr_scan_done");
    tick(4);
    check("clear_vs_store_valid", o_result_valid, 8'h01);
    check("clr_done_count", done_cnt - base, 1);
    check("clr_sb_drained", exp_ch_q.size(), 0);
    i_rd_ch = 3'd0;
    #1;
    check("clr_rd_data", o_rd_data, 12'h100);

    // Continuous with a comfortable period: starts exactly 2000 apart.
    pulse_clear();
    sb_en = 1'b0;
    ch0_rises.delete();
    i_ch_enable = 8'h03;
    i_scan_period = 24'd2000;
    i_continuous = 1'b1;
    pulse_start();
    n = 0;
    while (ch0_rises.size() < 3 && n < 8000) begin
      tick(1);
      n++;
    end
    check("period_rises_seen", longint'(ch0_rises.size() >= 3), 1);
    if (ch0_rises.size() >= 3) begin
      check("period_gap1", ch0_rises[1] - ch0_rises[0], 2000);
      check("period_gap2", ch0_rises[2] - ch0_rises[1], 2000);
    end
    check("period_no_overrun", o_overrun, 0);
    i_continuous = 1'b0;
    wait_idle(3000, "period_stop_idle");
    tick(2100);
    check("period_no_rescan", ch0_rises.size(), 3);
    check("period_still_idle", o_busy, 0);

    // Continuous with a too-short period: overrun, back-to-back scans.
    pulse_clear();
    i_ch_enable = 8'hFF;
    i_scan_period = 24'd500;
    i_continuous = 1'b1;
    base = done_cnt;
    pulse_start();
    wait_done(base, 5000, "ovr_first_done");
    ia = idle_cnt;
    wait_done(base + 2, 9000, "ovr_third_done");
    ib = idle_cnt;
    check("overrun_set", o_overrun, 1);
    check("back_to_back_idle_cycles", ib - ia, 0);
    i_continuous = 1'b0;
    d = done_cnt;
    wait_idle(5000, "ovr_stop_idle");
    tick(3);
    check("finish_then_idle", done_cnt - d, 1);
    check("ovr_valid", o_result_valid, 8'hFF);
    pulse_clear();
    check("clear_overrun", o_overrun, 0);
    check("clear_valid", o_result_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
